dec_bram_port_arbiter: RTL and testbench
========================================

// Module: dec_bram_port_arbiter
// PURPOSE
//  Parametrised owner-based port arbiter for one simple-dual-port polynomial BRAM (1 write port, 1 read port).
//  It replaces the per-state combinational port mux with a registered arbiter that serves NUM_CH datapath
//  requesters (PAcc, INTT, Sub, Reduce, Hash, Add, ...). The top controller names one owner channel per phase.
//  The block tracks reads in flight and routes BRAM read data back to the channel that issued each read.
//  On an owner change it drains the in-flight reads before handing the port to the new owner.
// PARAMETERS
//  NUM_CH    4    number of requester channels (2..8)
//  DW        128  BRAM data width (bits)
//  WAW       8    write address width
//  RAW       3    read address width
//  RD_LAT    2    BRAM read latency: cycles from bram_ren/bram_rad registered to bram_rdata valid (1..4)
//  DRAIN_CYC 1    minimum dead cycles between two owners (0..3)
//  CW = $clog2(NUM_CH) (localparam)
// PORTS
//  clk         in   1          clock, all logic rising-edge
//  rst         in   1          synchronous reset, active-high
//  sel_valid   in   1          controller requests an owner
//  ch_sel      in   CW         requested owner channel index
//  ch_wen      in   NUM_CH     per-channel write enable
//  ch_wad      in   NUM_CH*WAW per-channel write address, channel i at [i*WAW +: WAW]
//  ch_wdata    in   NUM_CH*DW  per-channel write data, channel i at [i*DW +: DW]
//  ch_ren      in   NUM_CH     per-channel read enable
//  ch_rad      in   NUM_CH*RAW per-channel read address
//  bram_wen    out  1          BRAM write enable (registered)
//  bram_wad    out  WAW        BRAM write address (registered)
//  bram_wdata  out  DW         BRAM write data (registered)
//  bram_ren    out  1          BRAM read enable (registered)
//  bram_rad    out  RAW        BRAM read address (registered)
//  bram_rdata  in   DW         BRAM read data
//  ch_rvalid   out  NUM_CH     one-hot read-return strobe (registered)
//  ch_rdata    out  DW         read-return data, shared across channels, qualified by ch_rvalid
//  busy        out  1          1 in ACTIVE or DRAIN
//  err         out  2          sticky: [0] non-owner wen/ren seen, [1] ch_sel >= NUM_CH requested
//  err_clr     in   1          clears err (set takes priority in the same cycle)
// BEHAVIOUR
//  Reset: state=IDLE, owner=0, all bram_* outputs 0, ch_rvalid=0, ch_rdata=0, err=0.
//   The read-tag pipeline is flushed; no ch_rvalid is issued for reads dropped by a reset.
//  FSM
//   IDLE:   bram_wen=bram_ren=0. If sel_valid and ch_sel<NUM_CH: owner<=ch_sel, go to ACTIVE.
//   ACTIVE: each cycle bram_wen/wad/wdata/ren/rad <= owner's ch_* (latency 1 cycle).
//           If !sel_valid or ch_sel!=owner: go to DRAIN. bram_wen and bram_ren are 0 from that cycle's update on.
//   DRAIN:  bram_wen=bram_ren=0. Exit only when the tag pipeline is empty and at least DRAIN_CYC cycles have passed.
//           On exit: if sel_valid and ch_sel valid, owner<=ch_sel and go to ACTIVE; otherwise go to IDLE.
//           If sel_valid returns with the old owner during DRAIN, DRAIN still completes.
//  Read return: each registered bram_ren pushes {1,owner} into a RD_LAT-deep tag shift register.
//   When a tag exits: ch_rdata<=bram_rdata and ch_rvalid[tag]<=1 for one cycle.
//   Latency from ch_ren to ch_rvalid is RD_LAT+2 cycles; with the defaults this is 4.
//  Write and read issued in the same cycle are both forwarded. Read-during-write ordering is the BRAM's.
//  Non-owner ch_wen/ch_ren are never forwarded; in ACTIVE they set err[0]. Requests are not checked in IDLE or DRAIN.
//  ch_sel>=NUM_CH with sel_valid=1: sets err[1]; treated as !sel_valid.
//  Back-to-back reads by the owner are sustained at 1 per cycle, with no bubbles.
// TESTING
//  T1 reset: hold rst 3 cycles with all ch_* driven active -> every output 0, busy=0, err=0.
//  T2 write path: sel ch2, ch_wen[2]=1, wad=8'h5A, wdata=128'hA5..A5 -> bram_wen=1, wad=5A, data A5.. exactly 1 cycle later.
//  T3 read return: owner ch1, reads rad=0..7 on consecutive cycles, RD_LAT=2
//     -> ch_rvalid=4'b0010 for 8 consecutive cycles starting 4 cycles after the first read, data in order.
//  T4 owner switch: ch1 issues reads, then ch_sel->3 on the cycle after the last read
//     -> DRAIN until the last ch1 return plus DRAIN_CYC; the first ch3 write reaches the BRAM only afterwards.
//  T5 foreign access: owner ch0, ch_wen[3]=1 -> bram_wen stays 0, err=2'b01 sticky; err_clr=1 -> err=0.
//  T6 reset mid-read: rst during the RD_LAT window -> no ch_rvalid afterwards, state IDLE;
//     also ch_sel=5 with NUM_CH=4 -> err[1]=1 and the state stays IDLE.

Source files
------------

// File: rtl/dec_bram_port_arbiter.sv
// Owner-based port arbiter for one simple-dual-port polynomial BRAM.
// Exactly one requester channel owns the BRAM ports at a time. It drives the
// registered write and read ports, and read data is routed back to the channel
// that issued each read. When the owner changes, the reads still in flight are
// drained before the new owner gets the ports.
module dec_bram_port_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int DW        = 128,
  parameter int WAW       = 8,
  parameter int RAW       = 3,
  parameter int RD_LAT    = 2,
  parameter int DRAIN_CYC = 1,
  localparam int CW       = $clog2(NUM_CH),
  // The select port has one extra bit so that an out-of-range request can be
  // represented and flagged in err[1].
  localparam int SW       = CW + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_sel_valid,
  input  logic [SW-1:0]         i_ch_sel,
  input  logic [NUM_CH-1:0]     i_ch_wen,
  input  logic [NUM_CH*WAW-1:0] i_ch_wad,
  input  logic [NUM_CH*DW-1:0]  i_ch_wdata,
  input  logic [NUM_CH-1:0]     i_ch_ren,
  input  logic [NUM_CH*RAW-1:0] i_ch_rad,
  output logic                  o_bram_wen,
  output logic [WAW-1:0]        o_bram_wad,
  output logic [DW-1:0]         o_bram_wdata,
  output logic                  o_bram_ren,
  output logic [RAW-1:0]        o_bram_rad,
  input  logic [DW-1:0]         i_bram_rdata,
  output logic [NUM_CH-1:0]     o_ch_rvalid,
  output logic [DW-1:0]         o_ch_rdata,
  output logic                  o_busy,
  output logic [1:0]            o_err,
  input  logic                  i_err_clr
);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

  // One entry per read in flight: the valid bit and the channel it returns to.
  typedef struct packed {
    logic          vld;
    logic [CW-1:0] ch;
  } tag_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_owner, w_owner_nxt;
  logic [1:0]      r_drain_cnt;
  tag_t            r_tag [RD_LAT];

  logic            r_bram_wen, r_bram_ren;
  logic [WAW-1:0]  r_bram_wad;
  logic [DW-1:0]   r_bram_wdata;
  logic [RAW-1:0]  r_bram_rad;
  logic [NUM_CH-1:0] r_ch_rvalid;
  logic [DW-1:0]   r_ch_rdata;
  logic [1:0]      r_err;

  logic            w_sel_in_range, w_sel_ok, w_sel_bad, w_keep, w_fwd;
  logic [CW-1:0]   w_sel_ch;
  logic [NUM_CH-1:0] w_owner_oh;
  logic            w_foreign, w_pipe_empty, w_drain_done;
  logic            w_own_wen, w_own_ren;
  logic [WAW-1:0]  w_own_wad;
  logic [DW-1:0]   w_own_wdata;
  logic [RAW-1:0]  w_own_rad;
  logic [1:0]      w_err_set;

  // An out-of-range select counts as no request at all.
  assign w_sel_in_range = (i_ch_sel < SW'(NUM_CH));
  assign w_sel_ok       = i_sel_valid && w_sel_in_range;
  assign w_sel_bad      = i_sel_valid && !w_sel_in_range;
  assign w_sel_ch       = i_ch_sel[CW-1:0];
  // The current owner keeps the ports only while it is still the one selected.
  assign w_keep         = w_sel_ok && (w_sel_ch == r_owner);
  assign w_fwd          = (r_state == S_ACTIVE) && w_keep;

  // The owner's request lanes.
  assign w_own_wen   = i_ch_wen[r_owner];
  assign w_own_ren   = i_ch_ren[r_owner];
  assign w_own_wad   = i_ch_wad[r_owner*WAW +: WAW];
  assign w_own_wdata = i_ch_wdata[r_owner*DW +: DW];
  assign w_own_rad   = i_ch_rad[r_owner*RAW +: RAW];

  assign w_owner_oh  = NUM_CH'(1) << r_owner;
  assign w_foreign   = |((i_ch_wen | i_ch_ren) & ~w_owner_oh);
  assign w_err_set   = {w_sel_bad, (r_state == S_ACTIVE) && w_foreign};

  assign w_drain_done = (int'(r_drain_cnt) >= DRAIN_CYC);

  // The pipeline is empty once no issued read is waiting for its data.
  always_comb begin
    w_pipe_empty = !r_bram_ren;
    for (int k = 0; k < RD_LAT; k++) begin
      if (r_tag[k].vld) w_pipe_empty = 1'b0;
    end
  end

  // State and owner register.
  always_ff @(posedge i_clk) begin
    // NOTE: state is updated with non-blocking assignments, so every process
    // sees the values from before the clock edge.
    if (i_rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
    end
  end

  // Next-state logic: hand over ownership and drain reads between owners.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    case (r_state)
      S_IDLE: begin
        if (w_sel_ok) begin
          w_owner_nxt = w_sel_ch;
          w_state_nxt = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (!w_keep) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_pipe_empty && w_drain_done) begin
          if (w_sel_ok) begin
            w_owner_nxt = w_sel_ch;
            w_state_nxt = S_ACTIVE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Count the cycles spent in DRAIN. The count saturates and is cleared outside DRAIN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_drain_cnt <= '0;
    end else if (r_state == S_DRAIN) begin
      if (r_drain_cnt != 2'd3) r_drain_cnt <= r_drain_cnt + 2'd1;
    end else begin
      r_drain_cnt <= '0;
    end
  end

  // Register the owner's BRAM requests. The enables are forced low outside forwarding.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_bram_wen   <= 1'b0;
      r_bram_ren   <= 1'b0;
      r_bram_wad   <= '0;
      r_bram_wdata <= '0;
      r_bram_rad   <= '0;
    end else begin
      r_bram_wen <= w_fwd && w_own_wen;
      r_bram_ren <= w_fwd && w_own_ren;
      if (w_fwd) begin
        r_bram_wad   <= w_own_wad;
        r_bram_wdata <= w_own_wdata;
        r_bram_rad   <= w_own_rad;
      end
    end
  end

  // Tag shift register that tracks the BRAM read latency for each issued read.
  always_ff @(posedge i_clk) begin
    // NOTE: this small array is reset on purpose. Flushing it guarantees that
    // a read dropped by reset never produces a return strobe. Large data
    // memories are not reset this way.
    if (i_rst) begin
      for (int k = 0; k < RD_LAT; k++) r_tag[k] <= '0;
    end else begin
      r_tag[0].vld <= r_bram_ren;
      r_tag[0].ch  <= r_owner;
      for (int k = 1; k < RD_LAT; k++) r_tag[k] <= r_tag[k-1];
    end
  end

  // Read return: capture the BRAM data and strobe the channel named in the tag.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ch_rvalid <= '0;
      r_ch_rdata  <= '0;
    end else begin
      r_ch_rvalid <= r_tag[RD_LAT-1].vld ? (NUM_CH'(1) << r_tag[RD_LAT-1].ch) : '0;
      if (r_tag[RD_LAT-1].vld) r_ch_rdata <= i_bram_rdata;
    end
  end

  // Sticky error flags. A set wins over a clear in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_err <= '0;
    else       r_err <= (r_err & {2{~i_err_clr}}) | w_err_set;
  end

  assign o_bram_wen   = r_bram_wen;
  assign o_bram_wad   = r_bram_wad;
  assign o_bram_wdata = r_bram_wdata;
  assign o_bram_ren   = r_bram_ren;
  assign o_bram_rad   = r_bram_rad;
  assign o_ch_rvalid  = r_ch_rvalid;
  assign o_ch_rdata   = r_ch_rdata;
  assign o_busy       = (r_state != S_IDLE);
  assign o_err        = r_err;

endmodule

// File: tb/tb_dec_bram_port_arbiter.sv
// Directed testbench for dec_bram_port_arbiter with a behavioural BRAM (read latency 2).
module tb_dec_bram_port_arbiter;

  localparam int NUM_CH = 4;
  localparam int DW     = 128;
  localparam int WAW    = 8;
  localparam int RAW    = 3;
  localparam logic [DW-1:0] BAD_WORD = {8{16'hDEAD}};

  logic                  clk;
  logic                  rst;
  logic                  sel_valid;
  logic [2:0]            ch_sel;
  logic [NUM_CH-1:0]     ch_wen;
  logic [NUM_CH*WAW-1:0] ch_wad;
  logic [NUM_CH*DW-1:0]  ch_wdata;
  logic [NUM_CH-1:0]     ch_ren;
  logic [NUM_CH*RAW-1:0] ch_rad;
  logic                  bram_wen;
  logic [WAW-1:0]        bram_wad;
  logic [DW-1:0]         bram_wdata;
  logic                  bram_ren;
  logic [RAW-1:0]        bram_rad;
  logic [DW-1:0]         bram_rdata;
  logic [NUM_CH-1:0]     ch_rvalid;
  logic [DW-1:0]         ch_rdata;
  logic                  busy;
  logic [1:0]            err;
  logic                  err_clr;

  int n_vec = 0;
  int n_miscmp = 0;

  dec_bram_port_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_sel_valid  (sel_valid),
    .i_ch_sel     (ch_sel),
    .i_ch_wen     (ch_wen),
    .i_ch_wad     (ch_wad),
    .i_ch_wdata   (ch_wdata),
    .i_ch_ren     (ch_ren),
    .i_ch_rad     (ch_rad),
    .o_bram_wen   (bram_wen),
    .o_bram_wad   (bram_wad),
    .o_bram_wdata (bram_wdata),
    .o_bram_ren   (bram_ren),
    .o_bram_rad   (bram_rad),
    .i_bram_rdata (bram_rdata),
    .o_ch_rvalid  (ch_rvalid),
    .o_ch_rdata   (ch_rdata),
    .o_busy       (busy),
    .o_err        (err),
    .i_err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents: every byte of the word at address a is 0x90 | a.
  function automatic logic [DW-1:0] mem_word(input logic [RAW-1:0] a);
    mem_word = {16{5'b10010, a}};
  endfunction

  // BRAM with two cycles from the registered read request to valid data.
  logic [DW-1:0] bram_d1 = '0;
  logic [DW-1:0] bram_d2 = '0;
  always @(posedge clk) begin
    bram_d1 <= bram_ren ? mem_word(bram_rad) : BAD_WORD;
    bram_d2 <= bram_d1;
  end
  assign bram_rdata = bram_d2;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock. Outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle(input string tag);
    sel_valid = 1'b0;
    ch_wen    = '0;
    ch_ren    = '0;
    repeat (4) step();
    check(tag, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // T1: reset with every input active
    rst = 1'b1; sel_valid = 1'b1; ch_sel = 3'd1; err_clr = 1'b0;
    ch_wen = '1; ch_ren = '1; ch_wad = '1; ch_wdata = '1; ch_rad = '1;
    repeat (3) step();
    check("t1_bram_wen",   bram_wen,   1'b0);
    check("t1_bram_wad",   bram_wad,   '0);
    check("t1_bram_wdata", bram_wdata, '0);
    check("t1_bram_ren",   bram_ren,   1'b0);
    check("t1_bram_rad",   bram_rad,   '0);
    check("t1_ch_rvalid",  ch_rvalid,  '0);
    check("t1_ch_rdata",   ch_rdata,   '0);
    check("t1_busy",       busy,       1'b0);
    check("t1_err",        err,        2'b00);
    rst = 1'b0; sel_valid = 1'b0; ch_wen = '0; ch_ren = '0;
    step();
    check("t1_idle_busy", busy, 1'b0);

    // T2: write path through ch2, then a write and a read in the same cycle
    for (int i = 0; i < NUM_CH; i++) begin
      ch_wad[i*WAW +: WAW] = 8'(8'h10 * i + 1);
      ch_wdata[i*DW +: DW] = {16{8'(8'h11 * (i + 1))}};
      ch_rad[i*RAW +: RAW] = 3'(7 - i);
    end
    ch_wad[2*WAW +: WAW] = 8'h5A;
    ch_wdata[2*DW +: DW] = {16{8'hA5}};
    sel_valid = 1'b1; ch_sel = 3'd2;
    step();
    check("t2_busy_active", busy, 1'b1);
    check("t2_wen_pre", bram_wen, 1'b0);
    ch_wen = 4'b0100;
    step();
    check("t2_wen", bram_wen, 1'b1);
    check("t2_wad", bram_wad, 8'h5A);
    check("t2_wdata", bram_wdata, {16{8'hA5}});
    check("t2_err", err, 2'b00);
    ch_ren = 4'b0100; ch_rad[2*RAW +: RAW] = 3'd3;
    step();
    check("t2_wr_wen", bram_wen, 1'b1);
    check("t2_wr_ren", bram_ren, 1'b1);
    check("t2_wr_rad", bram_rad, 3'd3);
    ch_wen = '0; ch_ren = '0; sel_valid = 1'b0;
    step();
    check("t2_drain_busy", busy, 1'b1);
    check("t2_drain_ren", bram_ren, 1'b0);
    step();
    check("t2_rvalid_early", ch_rvalid, 4'b0000);
    step();
    check("t2_rvalid", ch_rvalid, 4'b0100);
    check("t2_rdata", ch_rdata, mem_word(3'd3));
    step();
    check("t2_idle", busy, 1'b0);

    // T3: eight back-to-back reads by ch1, returned four cycles later in order
    sel_valid = 1'b1; ch_sel = 3'd1;
    step();
    for (int i = 0; i < 14; i++) begin
      ch_ren = (i < 8) ? 4'b0010 : 4'b0000;
      ch_rad[1*RAW +: RAW] = 3'(i);
      step();
      if (i >= 3 && i <= 10) begin
        check($sformatf("t3_rvalid_%0d", i), ch_rvalid, 4'b0010);
        check($sformatf("t3_rdata_%0d", i), ch_rdata, mem_word(3'(i - 3)));
      end else begin
        check($sformatf("t3_rvalid_%0d", i), ch_rvalid, 4'b0000);
      end
    end

    // T4: owner switch from ch1 to ch3 right after ch1's last read
    ch_ren = 4'b0010; ch_rad[1*RAW +: RAW] = 3'd5;
    step();
    ch_rad[1*RAW +: RAW] = 3'd6;
    step();
    check("t4_last_ren", bram_ren, 1'b1);
    check("t4_last_rad", bram_rad, 3'd6);
    ch_ren = '0; ch_sel = 3'd3;
    step();
    check("t4_drain_busy", busy, 1'b1);
    check("t4_drain_ren", bram_ren, 1'b0);
    ch_wen = 4'b1000; ch_wad[3*WAW +: WAW] = 8'hC3; ch_wdata[3*DW +: DW] = {16{8'h3C}};
    step();
    check("t4_ret5_valid", ch_rvalid, 4'b0010);
    check("t4_ret5_data", ch_rdata, mem_word(3'd5));
    check("t4_wen_l3", bram_wen, 1'b0);
    step();
    check("t4_ret6_valid", ch_rvalid, 4'b0010);
    check("t4_ret6_data", ch_rdata, mem_word(3'd6));
    check("t4_wen_l4", bram_wen, 1'b0);
    step();
    check("t4_rvalid_l5", ch_rvalid, 4'b0000);
    check("t4_wen_l5", bram_wen, 1'b0);
    check("t4_busy_l5", busy, 1'b1);
    step();
    check("t4_wen_l6", bram_wen, 1'b1);
    check("t4_wad_l6", bram_wad, 8'hC3);
    check("t4_wdata_l6", bram_wdata, {16{8'h3C}});
    check("t4_err", err, 2'b00);
    go_idle("t4_idle");

    // T5: foreign accesses while ch0 owns the ports
    sel_valid = 1'b1; ch_sel = 3'd0;
    step();
    ch_wen = 4'b1000;
    step();
    check("t5_wen_blocked", bram_wen, 1'b0);
    check("t5_err_set", err, 2'b01);
    ch_wen = '0;
    step();
    check("t5_err_sticky", err, 2'b01);
    err_clr = 1'b1; ch_ren = 4'b0100;
    step();
    check("t5_set_over_clr", err, 2'b01);
    check("t5_ren_blocked", bram_ren, 1'b0);
    ch_ren = '0;
    step();
    check("t5_err_clr", err, 2'b00);
    err_clr = 1'b0;
    go_idle("t5_idle");

    // T6: reset while a read is in flight, then an out-of-range select
    sel_valid = 1'b1; ch_sel = 3'd1;
    step();
    ch_ren = 4'b0010; ch_rad[1*RAW +: RAW] = 3'd4;
    step();
    check("t6_ren", bram_ren, 1'b1);
    ch_ren = '0;
    step();
    rst = 1'b1;
    step();
    check("t6_rst_busy", busy, 1'b0);
    check("t6_rst_rvalid", ch_rvalid, 4'b0000);
    rst = 1'b0; sel_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("t6_no_rvalid_%0d", i), ch_rvalid, 4'b0000);
    end
    sel_valid = 1'b1; ch_sel = 3'd5;
    step();
    check("t6_bad_sel_err", err, 2'b10);
    check("t6_bad_sel_busy", busy, 1'b0);
    step();
    check("t6_bad_sel_idle", busy, 1'b0);
    sel_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
